// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl: circular FIFO between the UART shifters and the CPU register interface.
// Latency: pop/peek data is registered (valid the cycle after the op). Status flags come
// straight from the registered count. Full policy: overwrite oldest (full_mode=0) or drop new (1).
// Optional: define UART_FIFO_DROP_CNT_EN to add the 16-bit saturating drop_cnt output.
module uart_fifo_ctrl #(
  parameter int              WIDTH     = 32,
  parameter int              DEPTH     = 16,
  parameter logic [WIDTH-1:0] EMPTY_VAL = {WIDTH{1'b1}},
  parameter int              AFULL_LVL = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       full_mode,
  input  logic [1:0]                 rd_op,
  input  logic                       overflow_clr,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic                       overflow
`ifdef UART_FIFO_DROP_CNT_EN
  ,
  output logic [15:0]                drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] OP_IDLE  = 2'b00;
  localparam logic [1:0] OP_POP   = 2'b01;
  localparam logic [1:0] OP_PEEK  = 2'b10;
  localparam logic [1:0] OP_FLUSH = 2'b11;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  logic is_pop;
  logic is_peek;
  logic is_flush;
  logic pop_ok;
  logic wr_store;
  logic wr_evict;
  logic wr_lost;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Status flags decoded from the registered occupancy.
  always_comb begin
    empty       = (count == '0);
    full        = (count == CW'(DEPTH));
    almost_full = (count >= CW'(AFULL_LVL));
  end

  // Decode the read op and classify this cycle's write.
  // A pop on a full FIFO frees a slot, so a same-cycle write is never lost.
  always_comb begin
    is_pop   = (rd_op == OP_POP);
    is_peek  = (rd_op == OP_PEEK);
    is_flush = (rd_op == OP_FLUSH);
    pop_ok   = is_pop && !empty;
    wr_lost  = wr_en && !is_flush && full && !pop_ok;
    wr_evict = wr_lost && !full_mode;
    wr_store = wr_en && !is_flush && (!full || pop_ok || !full_mode);
  end

  // Storage array; deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset && wr_store) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping; an eviction moves rd_ptr with wr_ptr.
  always_ff @(posedge clk) begin
    if (reset || is_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_store) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop_ok || wr_evict) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({wr_store && !wr_evict, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered read port: pop and peek share the path, flush and idle only drop valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else if (is_pop || is_peek) begin
      rd_data  <= empty ? EMPTY_VAL : mem[rd_ptr];
      rd_valid <= !empty;
    end else begin
      rd_valid <= 1'b0;
    end
  end

  // Sticky overflow; a new loss in the same cycle beats the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (wr_lost) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

`ifdef UART_FIFO_DROP_CNT_EN
  // Saturating count of lost words; a clear coinciding with a loss leaves 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (overflow_clr) begin
      drop_cnt <= wr_lost ? 16'd1 : 16'd0;
    end else if (wr_lost && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

  // OP_IDLE needs no action beyond the defaults above.
  logic unused_idle;
  always_comb unused_idle = (rd_op == OP_IDLE);

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// tb_uart_fifo_ctrl: directed tests for uart_fifo_ctrl, DEPTH=16/WIDTH=32 and DEPTH=5/WIDTH=8.
// Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
// Checks drop_cnt when UART_FIFO_DROP_CNT_EN is defined.
module tb_uart_fifo_ctrl;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] POP   = 2'b01;
  localparam logic [1:0] PEEK  = 2'b10;
  localparam logic [1:0] FLUSH = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   checks   = 0;
  int   failures = 0;

  // DUT A: default parameters
  logic        a_wr_en, a_full_mode, a_overflow_clr;
  logic [31:0] a_wr_data;
  logic [1:0]  a_rd_op;
  logic [31:0] a_rd_data;
  logic        a_rd_valid, a_empty, a_full, a_almost_full, a_overflow;
  logic [4:0]  a_count;
`ifdef UART_FIFO_DROP_CNT_EN
  logic [15:0] a_drop_cnt;
`endif

  // DUT B: DEPTH=5, WIDTH=8
  logic        b_wr_en, b_full_mode, b_overflow_clr;
  logic [7:0]  b_wr_data;
  logic [1:0]  b_rd_op;
  logic [7:0]  b_rd_data;
  logic        b_rd_valid, b_empty, b_full, b_almost_full, b_overflow;
  logic [2:0]  b_count;
`ifdef UART_FIFO_DROP_CNT_EN
  logic [15:0] b_drop_cnt;
`endif

  uart_fifo_ctrl dut_a (
    .clk(clk), .reset(reset), .wr_en(a_wr_en), .wr_data(a_wr_data),
    .full_mode(a_full_mode), .rd_op(a_rd_op), .overflow_clr(a_overflow_clr),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid), .count(a_count), .empty(a_empty),
    .full(a_full), .almost_full(a_almost_full), .overflow(a_overflow)
`ifdef UART_FIFO_DROP_CNT_EN
    , .drop_cnt(a_drop_cnt)
`endif
  );

  uart_fifo_ctrl #(.WIDTH(8), .DEPTH(5)) dut_b (
    .clk(clk), .reset(reset), .wr_en(b_wr_en), .wr_data(b_wr_data),
    .full_mode(b_full_mode), .rd_op(b_rd_op), .overflow_clr(b_overflow_clr),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .count(b_count), .empty(b_empty),
    .full(b_full), .almost_full(b_almost_full), .overflow(b_overflow)
`ifdef UART_FIFO_DROP_CNT_EN
    , .drop_cnt(b_drop_cnt)
`endif
  );

  // One clock of stimulus on DUT A, then return inputs to idle.
  task automatic cyc_a(input logic we, input logic [31:0] wd, input logic mode,
                       input logic [1:0] op, input logic clr);
    a_wr_en = we; a_wr_data = wd; a_full_mode = mode; a_rd_op = op; a_overflow_clr = clr;
    @(posedge clk); #1;
    a_wr_en = 1'b0; a_rd_op = IDLE; a_overflow_clr = 1'b0;
  endtask

  task automatic cyc_b(input logic we, input logic [7:0] wd, input logic mode,
                       input logic [1:0] op, input logic clr);
    b_wr_en = we; b_wr_data = wd; b_full_mode = mode; b_rd_op = op; b_overflow_clr = clr;
    @(posedge clk); #1;
    b_wr_en = 1'b0; b_rd_op = IDLE; b_overflow_clr = 1'b0;
  endtask

  task automatic fill_a(input logic mode);
    for (int i = 1; i <= 16; i++) cyc_a(1'b1, 32'(i), mode, IDLE, 1'b0);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    cyc_a(1'b1, 32'hDEAD_BEEF, 1'b0, POP, 1'b0);
    cyc_a(1'b1, 32'h1234_5678, 1'b0, PEEK, 1'b0);
    reset = 1'b0;
    checks++; if (a_count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", a_count); end
    checks++; if (a_empty !== 1'b1 || a_full !== 1'b0) begin failures++; $display("FAIL reset_flags empty=%b full=%b exp 1/0", a_empty, a_full); end
    checks++; if (a_rd_data !== 32'h0 || a_rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd got=%h/%b exp=0/0", a_rd_data, a_rd_valid); end
    checks++; if (a_overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", a_overflow); end
    checks++; if (b_count !== 3'd0 || b_empty !== 1'b1) begin failures++; $display("FAIL reset_b count=%0d empty=%b exp 0/1", b_count, b_empty); end
`ifdef UART_FIFO_DROP_CNT_EN
    checks++; if (a_drop_cnt !== 16'd0) begin failures++; $display("FAIL reset_drop_cnt got=%0d exp=0", a_drop_cnt); end
`endif
    cyc_a(1'b0, 32'h0, 1'b0, POP, 1'b0);
    checks++; if (a_rd_data !== 32'hFFFF_FFFF || a_rd_valid !== 1'b0) begin failures++; $display("FAIL empty_pop got=%h/%b exp=ffffffff/0", a_rd_data, a_rd_valid); end
    checks++; if (a_count !== 5'd0 || a_empty !== 1'b1) begin failures++; $display("FAIL empty_pop_count count=%0d empty=%b exp 0/1", a_count, a_empty); end
  endtask

  task automatic test_fill_drain;
    logic [4:0] ec;
    for (int i = 1; i <= 16; i++) begin
      cyc_a(1'b1, 32'(i), 1'b0, IDLE, 1'b0);
      ec = 5'(i);
      checks++; if (a_count !== ec) begin failures++; $display("FAIL fill_count got=%0d exp=%0d", a_count, ec); end
      checks++; if (a_almost_full !== (i >= 14)) begin failures++; $display("FAIL fill_afull at %0d got=%b", i, a_almost_full); end
      checks++; if (a_full !== (i == 16)) begin failures++; $display("FAIL fill_full at %0d got=%b", i, a_full); end
    end
    for (int i = 1; i <= 16; i++) begin
      cyc_a(1'b0, 32'h0, 1'b0, POP, 1'b0);
      ec = 5'(16 - i);
      checks++; if (a_rd_data !== 32'(i) || a_rd_valid !== 1'b1) begin failures++; $display("FAIL drain_data got=%0d/%b exp=%0d/1", a_rd_data, a_rd_valid, i); end
      checks++; if (a_count !== ec) begin failures++; $display("FAIL drain_count got=%0d exp=%0d", a_count, ec); end
    end
    checks++; if (a_empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b exp=1", a_empty); end
  endtask

  task automatic test_full_policy;
    fill_a(1'b0);
    cyc_a(1'b1, 32'd17, 1'b0, IDLE, 1'b0);
    cyc_a(1'b1, 32'd18, 1'b0, IDLE, 1'b0);
    checks++; if (a_overflow !== 1'b1 || a_count !== 5'd16) begin failures++; $display("FAIL ovw_state ovf=%b count=%0d exp 1/16", a_overflow, a_count); end
    for (int i = 3; i <= 18; i++) begin
      cyc_a(1'b0, 32'h0, 1'b0, POP, 1'b0);
      checks++; if (a_rd_data !== 32'(i)) begin failures++; $display("FAIL ovw_pop got=%0d exp=%0d", a_rd_data, i); end
    end
    cyc_a(1'b0, 32'h0, 1'b0, IDLE, 1'b1);
    checks++; if (a_overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", a_overflow); end
    fill_a(1'b1);
    cyc_a(1'b1, 32'd17, 1'b1, IDLE, 1'b0);
    cyc_a(1'b1, 32'd18, 1'b1, IDLE, 1'b0);
    checks++; if (a_overflow !== 1'b1 || a_count !== 5'd16) begin failures++; $display("FAIL drop_state ovf=%b count=%0d exp 1/16", a_overflow, a_count); end
    for (int i = 1; i <= 16; i++) begin
      cyc_a(1'b0, 32'h0, 1'b0, POP, 1'b0);
      checks++; if (a_rd_data !== 32'(i)) begin failures++; $display("FAIL drop_pop got=%0d exp=%0d", a_rd_data, i); end
    end
    cyc_a(1'b0, 32'h0, 1'b0, IDLE, 1'b1);
  endtask

  task automatic test_pop_write_full;
    logic [31:0] ed;
    fill_a(1'b0);
    cyc_a(1'b1, 32'd99, 1'b0, POP, 1'b0);
    checks++; if (a_rd_data !== 32'd1 || a_rd_valid !== 1'b1) begin failures++; $display("FAIL pw_pop got=%0d/%b exp=1/1", a_rd_data, a_rd_valid); end
    checks++; if (a_count !== 5'd16 || a_overflow !== 1'b0) begin failures++; $display("FAIL pw_state count=%0d ovf=%b exp 16/0", a_count, a_overflow); end
    for (int k = 0; k < 16; k++) begin
      cyc_a(1'b0, 32'h0, 1'b0, POP, 1'b0);
      ed = (k < 15) ? 32'(k + 2) : 32'd99;
      checks++; if (a_rd_data !== ed) begin failures++; $display("FAIL pw_drain got=%0d exp=%0d", a_rd_data, ed); end
    end
  endtask

  task automatic test_peek_flush;
    cyc_a(1'b1, 32'd5, 1'b0, IDLE, 1'b0);
    cyc_a(1'b1, 32'd6, 1'b0, IDLE, 1'b0);
    for (int k = 0; k < 2; k++) begin
      cyc_a(1'b0, 32'h0, 1'b0, PEEK, 1'b0);
      checks++; if (a_rd_data !== 32'd5 || a_rd_valid !== 1'b1 || a_count !== 5'd2) begin failures++; $display("FAIL peek got=%0d/%b count=%0d exp=5/1/2", a_rd_data, a_rd_valid, a_count); end
    end
    cyc_a(1'b1, 32'd7, 1'b0, FLUSH, 1'b0);
    checks++; if (a_count !== 5'd0 || a_empty !== 1'b1 || a_rd_valid !== 1'b0) begin failures++; $display("FAIL flush count=%0d empty=%b vld=%b exp 0/1/0", a_count, a_empty, a_rd_valid); end
    checks++; if (a_rd_data !== 32'd5) begin failures++; $display("FAIL flush_hold got=%0d exp=5", a_rd_data); end
    cyc_a(1'b0, 32'h0, 1'b0, POP, 1'b0);
    checks++; if (a_rd_data !== 32'hFFFF_FFFF || a_rd_valid !== 1'b0) begin failures++; $display("FAIL flush_pop got=%h/%b exp=ffffffff/0", a_rd_data, a_rd_valid); end
  endtask

  task automatic test_pop_write_empty;
    cyc_a(1'b1, 32'd42, 1'b0, POP, 1'b0);
    checks++; if (a_rd_data !== 32'hFFFF_FFFF || a_rd_valid !== 1'b0 || a_count !== 5'd1) begin failures++; $display("FAIL pwe got=%h/%b count=%0d exp=ffffffff/0/1", a_rd_data, a_rd_valid, a_count); end
    cyc_a(1'b0, 32'h0, 1'b0, POP, 1'b0);
    checks++; if (a_rd_data !== 32'd42 || a_rd_valid !== 1'b1 || a_count !== 5'd0) begin failures++; $display("FAIL pwe_pop got=%0d/%b count=%0d exp=42/1/0", a_rd_data, a_rd_valid, a_count); end
  endtask

  task automatic test_peek_overwrite_clr;
    fill_a(1'b0);
    cyc_a(1'b1, 32'd50, 1'b0, PEEK, 1'b0);
    checks++; if (a_rd_data !== 32'd1 || a_rd_valid !== 1'b1) begin failures++; $display("FAIL peek_ovw got=%0d/%b exp=1/1", a_rd_data, a_rd_valid); end
    checks++; if (a_count !== 5'd16 || a_overflow !== 1'b1) begin failures++; $display("FAIL peek_ovw_state count=%0d ovf=%b exp 16/1", a_count, a_overflow); end
    cyc_a(1'b0, 32'h0, 1'b0, POP, 1'b0);
    checks++; if (a_rd_data !== 32'd2) begin failures++; $display("FAIL peek_ovw_pop got=%0d exp=2", a_rd_data); end
    cyc_a(1'b0, 32'h0, 1'b0, FLUSH, 1'b0);
    checks++; if (a_overflow !== 1'b1 || a_count !== 5'd0) begin failures++; $display("FAIL flush_keeps_ovf ovf=%b count=%0d exp 1/0", a_overflow, a_count); end
    fill_a(1'b1);
    cyc_a(1'b1, 32'd77, 1'b1, IDLE, 1'b1);
    checks++; if (a_overflow !== 1'b1 || a_count !== 5'd16) begin failures++; $display("FAIL set_beats_clr ovf=%b count=%0d exp 1/16", a_overflow, a_count); end
    cyc_a(1'b0, 32'h0, 1'b0, IDLE, 1'b1);
    checks++; if (a_overflow !== 1'b0) begin failures++; $display("FAIL clr_alone got=%b exp=0", a_overflow); end
    cyc_a(1'b0, 32'h0, 1'b0, FLUSH, 1'b0);
  endtask

  task automatic test_depth5;
    for (int i = 1; i <= 8; i++) cyc_b(1'b1, 8'(i), 1'b0, IDLE, 1'b0);
    checks++; if (b_count !== 3'd5 || b_full !== 1'b1 || b_overflow !== 1'b1) begin failures++; $display("FAIL d5_state count=%0d full=%b ovf=%b exp 5/1/1", b_count, b_full, b_overflow); end
`ifdef UART_FIFO_DROP_CNT_EN
    checks++; if (b_drop_cnt !== 16'd3) begin failures++; $display("FAIL d5_drop_cnt got=%0d exp=3", b_drop_cnt); end
`endif
    for (int i = 4; i <= 8; i++) begin
      cyc_b(1'b0, 8'h0, 1'b0, POP, 1'b0);
      checks++; if (b_rd_data !== 8'(i) || b_rd_valid !== 1'b1) begin failures++; $display("FAIL d5_pop got=%0d/%b exp=%0d/1", b_rd_data, b_rd_valid, i); end
    end
    checks++; if (b_empty !== 1'b1) begin failures++; $display("FAIL d5_empty got=%b exp=1", b_empty); end
    cyc_b(1'b0, 8'h0, 1'b0, IDLE, 1'b1);
    checks++; if (b_overflow !== 1'b0) begin failures++; $display("FAIL d5_clr got=%b exp=0", b_overflow); end
`ifdef UART_FIFO_DROP_CNT_EN
    checks++; if (b_drop_cnt !== 16'd0) begin failures++; $display("FAIL d5_drop_clr got=%0d exp=0", b_drop_cnt); end
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    a_wr_en = 1'b0; a_wr_data = '0; a_full_mode = 1'b0; a_rd_op = IDLE; a_overflow_clr = 1'b0;
    b_wr_en = 1'b0; b_wr_data = '0; b_full_mode = 1'b0; b_rd_op = IDLE; b_overflow_clr = 1'b0;
    test_reset;
    test_fill_drain;
    test_full_policy;
    test_pop_write_full;
    test_peek_flush;
    test_pop_write_empty;
    test_peek_overwrite_clr;
    test_depth5;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
